// File: rtl/uart_tx_if.sv
// CPU-side start/busy bus for the UART transmitter.
// The master drives a one-cycle start with address/we/data; the slave answers with busy and q.
interface uart_tx_if;
  logic        start;
  logic        we;
  logic [1:0]  address;
  logic [31:0] data;
  logic        busy;
  logic [31:0] q;

  modport master (output start, we, address, data, input busy, q);
  modport slave  (input start, we, address, data, output busy, q);
endinterface

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: the bus side pushes bytes into a FIFO,
// and the TX FSM drains them onto uart_out at a programmable baud divisor.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic     clk,
  input  logic     nreset,
  uart_tx_if.slave bus,
  output logic     uart_out,
  output logic     tx_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {B_IDLE, B_ACK} bus_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  bus_state_t bstate;
  tx_state_t  tstate;

  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   div;

  logic          busy_r;
  logic [31:0]   q_r;
  logic [31:0]   rdata;

  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [15:0]   cnt;
  logic [15:0]   div_lat;

  logic accept, push_req, push, pop, full, empty, bit_end;
  logic [15:0] wr_div;
  logic unused_bits;

  assign bus.busy = busy_r;
  assign bus.q    = q_r;
  assign unused_bits = ^bus.data[31:16];

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign accept   = (bstate == B_IDLE) && bus.start;
  assign push_req = accept && bus.we && (bus.address == 2'd0);
  assign push     = push_req && !full;
  assign bit_end  = (cnt == div_lat - 16'd1);
  // Pops happen only from idle or at the very end of a stop bit, and only on pre-edge non-empty.
  assign pop      = !empty && ((tstate == T_IDLE) || (tstate == T_STOP && bit_end));
  assign wr_div   = (bus.data[15:0] < 16'd2) ? 16'd2 : bus.data[15:0];

  always_comb begin
    rdata = '0;
    case (bus.address)
      2'd1:    rdata = {16'b0, 8'(count), 5'b0, overflow, empty, full};
      2'd2:    rdata = {16'b0, div};
      default: rdata = '0;
    endcase
  end

  // Bus FSM: every access is exactly two cycles; register writes commit on the accepting edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bstate   <= B_IDLE;
      busy_r   <= 1'b0;
      q_r      <= '0;
      overflow <= 1'b0;
      div      <= 16'(CLKS_PER_BIT);
    end else begin
      case (bstate)
        B_IDLE: if (bus.start) begin
          busy_r <= 1'b1;
          bstate <= B_ACK;
          q_r    <= bus.we ? 32'd0 : rdata;
          if (bus.we) begin
            case (bus.address)
              2'd1:    if (bus.data[0]) overflow <= 1'b0;
              2'd2:    div <= wr_div;
              default: ;
            endcase
          end
        end
        B_ACK: begin
          busy_r <= 1'b0;
          bstate <= B_IDLE;
        end
        default: bstate <= B_IDLE;
      endcase
      if (push_req && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data[7:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // TX FSM: the divisor is latched with each popped byte so mid-frame writes wait for the next start bit.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tstate   <= T_IDLE;
      uart_out <= 1'b1;
      tx_done  <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      div_lat  <= 16'(CLKS_PER_BIT);
    end else begin
      tx_done <= 1'b0;
      case (tstate)
        T_IDLE: if (pop) begin
          shreg    <= mem[rd_ptr];
          div_lat  <= div;
          cnt      <= '0;
          uart_out <= 1'b0;
          tstate   <= T_START;
        end
        T_START: begin
          if (bit_end) begin
            cnt      <= '0;
            bit_idx  <= '0;
            uart_out <= shreg[0];
            tstate   <= T_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        T_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_out <= 1'b1;
              tstate   <= T_STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_out <= shreg[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        T_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shreg    <= mem[rd_ptr];
              div_lat  <= div;
              uart_out <= 1'b0;
              tstate   <= T_START;
            end else begin
              tx_done <= 1'b1;
              tstate  <= T_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: tstate <= T_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: bus transactions plus a waveform model built from queued bytes.
module tb_uart_tx;
  localparam int MAXC = 60000;

  logic clk = 1'b0;
  logic nreset;
  logic uart_out, tx_done;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic line_hist [0:MAXC-1];
  logic done_hist [0:MAXC-1];
  logic exp_line  [0:MAXC-1];
  logic [7:0] m_b [0:31];
  int   m_d [0:31];
  int   m_n;

  uart_tx_if bus_if();

  uart_tx #(.CLKS_PER_BIT(434), .FIFO_DEPTH(16)) dut (
    .clk(clk), .nreset(nreset), .bus(bus_if.slave), .uart_out(uart_out), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // hist[c] holds the outputs as they stand after rising edge number c.
  always @(negedge clk) if (cyc < MAXC) begin
    line_hist[cyc] <= uart_out;
    done_hist[cyc] <= tx_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference: a byte stream starting at cycle p0 is a run of 10-bit frames (0, d0..d7, 1),
  // each bit held for that frame's divisor; the line idles high on both sides.
  task automatic model_stream(input int p0, output int pend);
    int t;
    logic v;
    t = p0;
    exp_line[p0 - 1] = 1'b1;
    for (int i = 0; i < m_n; i++)
      for (int k = 0; k < 10; k++) begin
        v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_b[i][k - 1];
        for (int j = 0; j < m_d[i]; j++) begin
          exp_line[t] = v;
          t++;
        end
      end
    pend = t;
    for (int c = pend; c <= pend + 30; c++) exp_line[c] = 1'b1;
  endtask

  // Called #1 after a rising edge; returns q and the edge number that sampled start.
  task automatic bus_op(input logic w, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rq, output int n);
    bus_if.start = 1'b1; bus_if.we = w; bus_if.address = a; bus_if.data = d;
    @(posedge clk); #1;
    n = cyc;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
    rq = bus_if.q;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rq;
    int n;
    nreset = 1'b1;
    bus_if.start = 1'b0; bus_if.we = 1'b0; bus_if.address = '0; bus_if.data = '0;
    #2 nreset = 1'b0;
    #1;
    n_cmp++;
    if (uart_out !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.q !== 32'd0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: uart_out=%b busy=%b q=%h tx_done=%b, need 1/0/0/0",
               uart_out, bus_if.busy, bus_if.q, tx_done);
    end
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.we = 1'b0; bus_if.address = 2'd1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n_cmp++;
    if (bus_if.busy !== 1'b1) begin
      n_err++; $display("FAIL busy_rise: busy=%b need 1", bus_if.busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.q !== 32'h2) begin
      n_err++; $display("FAIL reset_status: busy=%b q=%h need 0/00000002", bus_if.busy, bus_if.q);
    end
    bus_op(1'b0, 2'd2, 32'd0, rq, n);
    n_cmp++;
    if (rq !== 32'd434) begin
      n_err++; $display("FAIL reset_div: q=%0d need 434", rq);
    end
  endtask

  task automatic test_single();
    logic [31:0] rq;
    int n, p0, pend, bad, nd;
    bus_op(1'b1, 2'd2, 32'd4, rq, n);
    bus_op(1'b1, 2'd0, 32'hA5, rq, n);
    p0 = n + 1;
    m_n = 1; m_b[0] = 8'hA5; m_d[0] = 4;
    model_stream(p0, pend);
    wait_until(pend + 33);
    n_cmp++;
    if (line_hist[n] !== 1'b1 || line_hist[p0] !== 1'b0) begin
      n_err++; $display("FAIL single_start_edge: line %b->%b need 1->0", line_hist[n], line_hist[p0]);
    end
    bad = -1;
    for (int c = p0 - 1; c <= pend + 30; c++) if (bad < 0 && line_hist[c] !== exp_line[c]) bad = c;
    n_cmp++;
    if (bad >= 0) begin
      n_err++; $display("FAIL single_wave: cycle %0d uart_out=%b need %b", bad - p0, line_hist[bad], exp_line[bad]);
    end
    nd = 0;
    for (int c = p0; c <= pend + 30; c++) nd += int'(done_hist[c]);
    n_cmp++;
    if (nd !== 1 || done_hist[pend] !== 1'b1) begin
      n_err++; $display("FAIL single_done: pulses=%0d at_end=%b need 1/1", nd, done_hist[pend]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rq;
    int n, n0, p0, pend, bad, nd;
    logic [7:0] vals [0:2];
    vals[0] = 8'h01; vals[1] = 8'h80; vals[2] = 8'hFF;
    bus_op(1'b1, 2'd2, 32'd2, rq, n);
    m_n = 3;
    for (int i = 0; i < 3; i++) begin
      bus_op(1'b1, 2'd0, {24'd0, vals[i]}, rq, n);
      if (i == 0) n0 = n;
      m_b[i] = vals[i]; m_d[i] = 2;
    end
    p0 = n0 + 1;
    model_stream(p0, pend);
    wait_until(pend + 33);
    bad = -1;
    for (int c = p0 - 1; c <= pend + 30; c++) if (bad < 0 && line_hist[c] !== exp_line[c]) bad = c;
    n_cmp++;
    if (bad >= 0) begin
      n_err++; $display("FAIL b2b_wave: cycle %0d uart_out=%b need %b", bad - p0, line_hist[bad], exp_line[bad]);
    end
    nd = 0;
    for (int c = p0; c <= pend + 30; c++) nd += int'(done_hist[c]);
    n_cmp++;
    if (nd !== 1 || done_hist[pend] !== 1'b1) begin
      n_err++; $display("FAIL b2b_done: pulses=%0d at_end=%b need 1/1", nd, done_hist[pend]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rq;
    int n, n0, p0, pend, bad, nd;
    bus_op(1'b1, 2'd2, 32'd1000, rq, n);
    for (int i = 0; i < 18; i++) begin
      bus_op(1'b1, 2'd0, 32'(i), rq, n);
      if (i == 0) n0 = n;
    end
    bus_op(1'b0, 2'd1, 32'd0, rq, n);
    n_cmp++;
    if (rq !== 32'h0000_1005) begin
      n_err++; $display("FAIL ovf_status: q=%h need 00001005", rq);
    end
    bus_op(1'b1, 2'd1, 32'd1, rq, n);
    bus_op(1'b0, 2'd1, 32'd0, rq, n);
    n_cmp++;
    if (rq !== 32'h0000_1001) begin
      n_err++; $display("FAIL ovf_clear: q=%h need 00001001", rq);
    end
    // Shrink the divisor for the queued bytes; the frame in flight keeps 1000.
    bus_op(1'b1, 2'd2, 32'd2, rq, n);
    m_n = 17;
    for (int i = 0; i < 17; i++) begin
      m_b[i] = 8'(i);
      m_d[i] = (i == 0) ? 1000 : 2;
    end
    p0 = n0 + 1;
    model_stream(p0, pend);
    wait_until(pend + 33);
    bad = -1;
    for (int c = p0 - 1; c <= pend + 30; c++) if (bad < 0 && line_hist[c] !== exp_line[c]) bad = c;
    n_cmp++;
    if (bad >= 0) begin
      n_err++; $display("FAIL ovf_wave: cycle %0d uart_out=%b need %b", bad - p0, line_hist[bad], exp_line[bad]);
    end
    nd = 0;
    for (int c = p0; c <= pend + 30; c++) nd += int'(done_hist[c]);
    n_cmp++;
    if (nd !== 1 || done_hist[pend] !== 1'b1) begin
      n_err++; $display("FAIL ovf_done: pulses=%0d at_end=%b need 1/1", nd, done_hist[pend]);
    end
  endtask

  task automatic test_div_change();
    logic [31:0] rq;
    int n, n0, p0, pend, bad;
    bus_op(1'b1, 2'd2, 32'd0, rq, n);
    bus_op(1'b0, 2'd2, 32'd0, rq, n);
    n_cmp++;
    if (rq !== 32'd2) begin
      n_err++; $display("FAIL clamp0: div=%0d need 2", rq);
    end
    bus_op(1'b1, 2'd2, 32'hFFFF_0001, rq, n);
    bus_op(1'b0, 2'd2, 32'd0, rq, n);
    n_cmp++;
    if (rq !== 32'd2) begin
      n_err++; $display("FAIL clamp1: div=%0d need 2", rq);
    end
    bus_op(1'b1, 2'd2, 32'd8, rq, n);
    bus_op(1'b1, 2'd0, 32'hC3, rq, n0);
    bus_op(1'b1, 2'd0, 32'h3C, rq, n);
    repeat (20) @(posedge clk);
    #1;
    bus_op(1'b1, 2'd2, 32'd3, rq, n);
    m_n = 2; m_b[0] = 8'hC3; m_d[0] = 8; m_b[1] = 8'h3C; m_d[1] = 3;
    p0 = n0 + 1;
    model_stream(p0, pend);
    wait_until(pend + 33);
    bad = -1;
    for (int c = p0 - 1; c <= pend + 30; c++) if (bad < 0 && line_hist[c] !== exp_line[c]) bad = c;
    n_cmp++;
    if (bad >= 0) begin
      n_err++; $display("FAIL divchg_wave: cycle %0d uart_out=%b need %b", bad - p0, line_hist[bad], exp_line[bad]);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] rq;
    int n, p0, pend, bad;
    bus_op(1'b1, 2'd2, 32'd2, rq, n);
    // start stays high into the ack cycle; that second cycle must not push again.
    bus_if.start = 1'b1; bus_if.we = 1'b1; bus_if.address = 2'd0; bus_if.data = 32'h3C;
    @(posedge clk); #1;
    n = cyc;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    m_n = 1; m_b[0] = 8'h3C; m_d[0] = 2;
    p0 = n + 1;
    model_stream(p0, pend);
    wait_until(pend + 33);
    bad = -1;
    for (int c = p0 - 1; c <= pend + 30; c++) if (bad < 0 && line_hist[c] !== exp_line[c]) bad = c;
    n_cmp++;
    if (bad >= 0) begin
      n_err++; $display("FAIL busy_ignore_wave: cycle %0d uart_out=%b need %b", bad - p0, line_hist[bad], exp_line[bad]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rq;
    int n, n0, p0, pend, bad, nd, dv;
    for (int it = 0; it < 3; it++) begin
      dv  = $urandom_range(5, 2);
      m_n = $urandom_range(6, 2);
      bus_op(1'b1, 2'd2, 32'(dv), rq, n);
      for (int i = 0; i < m_n; i++) begin
        m_b[i] = 8'($urandom);
        m_d[i] = dv;
        bus_op(1'b1, 2'd0, {$urandom_range(255, 0), m_b[i]}, rq, n);
        if (i == 0) n0 = n;
      end
      p0 = n0 + 1;
      model_stream(p0, pend);
      wait_until(pend + 33);
      bad = -1;
      for (int c = p0 - 1; c <= pend + 30; c++) if (bad < 0 && line_hist[c] !== exp_line[c]) bad = c;
      n_cmp++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL rand_wave[%0d]: div=%0d n=%0d cycle %0d uart_out=%b need %b",
                 it, dv, m_n, bad - p0, line_hist[bad], exp_line[bad]);
      end
      nd = 0;
      for (int c = p0; c <= pend + 30; c++) nd += int'(done_hist[c]);
      n_cmp++;
      if (nd !== 1 || done_hist[pend] !== 1'b1) begin
        n_err++; $display("FAIL rand_done[%0d]: pulses=%0d at_end=%b need 1/1", it, nd, done_hist[pend]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rq;
    int n, n0, p0, rel, bad, nd;
    bus_op(1'b1, 2'd2, 32'd4, rq, n);
    bus_op(1'b1, 2'd0, 32'h5A, rq, n0);
    bus_op(1'b1, 2'd0, 32'h11, rq, n);
    bus_op(1'b1, 2'd0, 32'h22, rq, n);
    bus_op(1'b0, 2'd2, 32'd0, rq, n);
    n_cmp++;
    if (rq !== 32'd4) begin
      n_err++; $display("FAIL mid_div_read: q=%0d need 4", rq);
    end
    p0 = n0 + 1;
    wait_until(p0 + 17);
    nreset = 1'b0;
    #2;
    n_cmp++;
    if (uart_out !== 1'b1 || bus_if.q !== 32'd0 || bus_if.busy !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async: uart_out=%b q=%h busy=%b tx_done=%b need 1/0/0/0",
               uart_out, bus_if.q, bus_if.busy, tx_done);
    end
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    rel = cyc;
    @(posedge clk); #1;
    bus_op(1'b0, 2'd1, 32'd0, rq, n);
    n_cmp++;
    if (rq !== 32'h2) begin
      n_err++; $display("FAIL mid_status: q=%h need 00000002", rq);
    end
    bus_op(1'b0, 2'd2, 32'd0, rq, n);
    n_cmp++;
    if (rq !== 32'd434) begin
      n_err++; $display("FAIL mid_div: q=%0d need 434", rq);
    end
    repeat (150) @(posedge clk);
    #1;
    bad = -1; nd = 0;
    for (int c = rel; c < cyc - 1; c++) begin
      if (bad < 0 && line_hist[c] !== 1'b1) bad = c;
      nd += int'(done_hist[c]);
    end
    n_cmp++;
    if (bad >= 0 || nd != 0) begin
      n_err++; $display("FAIL mid_quiet: first_low=%0d done_pulses=%0d need -1/0", bad, nd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_div_change();
    test_busy_ignore();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
